trng_collector: RTL and testbench
=================================

// Module: trng_collector
// PURPOSE
//  Consumer end of the ring-oscillator entropy path: takes the raw oscillator bit (already
//  registered in its own flop), resynchronises it, decimates, von Neumann-debiases it and packs
//  the unbiased bits into WIDTH-bit words. Each word goes to the TRNG consumer over a
//  valid/ready handshake. One instance sits per oscillator, between the oscillator and the pool.
// PARAMETERS
//  WIDTH     8   output word width in bits (>=2)
//  DECIM     4   take one raw sample every DECIM clocks (>=1)
//  REP_LIMIT 32  consecutive identical raw samples that trip the health alarm (>=2)
// PORTS
//  clock      in   1      single clock, all state on rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  enable     in   1      collection enable
//  raw_in     in   1      raw oscillator bit, asynchronous to clock
//  out_data   out  WIDTH  packed debiased word
//  out_valid  out  1      out_data holds a word
//  out_ready  in   1      consumer accepts the word
//  alarm      out  1      health-test failure, sticky
// BEHAVIOUR
//  - Reset values: out_data=0, out_valid=0, alarm=0. Also cleared: sync flops, decim counter,
//    pair state, shift register and bit count.
//  - Sync: raw_in -> s1 -> s2, two flops. s2 is the sampled value, 2 cycles behind raw_in.
//  - Decimation: counter 0..DECIM-1, advances each cycle while enable=1. A sample is taken
//    when counter==DECIM-1, and the counter then wraps to 0. DECIM=1: sample every cycle.
//  - Debias FSM, two states.
//    EMPTY: on a sample, store it as first and go to HAVE_FIRST.
//    HAVE_FIRST: on a sample, if it differs from first, emit first (pair 10->1, 01->0);
//    if equal, emit nothing. Either way go back to EMPTY.
//  - Packing: sreg <= {sreg[WIDTH-2:0], bit}, so the first emitted bit ends at the MSB.
//    bit_cnt counts 0..WIDTH.
//  - Word complete (bit_cnt reaches WIDTH): moves to out_data/out_valid=1 on the cycle after
//    the completing bit. The move happens if out_valid=0 or out_ready=1 that cycle.
//    The move resets bit_cnt to 0.
//  - Backpressure: while a completed word waits (bit_cnt==WIDTH and out_valid=1, no ready),
//    newly emitted bits are dropped. The pending word is never overwritten.
//  - Handshake: a transfer occurs when out_valid & out_ready. out_data is stable while
//    out_valid=1 and out_ready=0. out_valid falls the cycle after a transfer, unless a pending
//    word loads on that same edge; then back-to-back valid with the new data.
//  - enable=0: decim counter, FSM (to EMPTY) and the rep-test run are cleared. sreg, bit_cnt
//    and any held output word are kept, and the output handshake still operates.
//  - Reset mid-operation: immediate clear. A partial word is lost, and out_valid drops
//    asynchronously.
// CONFIGURATION
//  TRNG_HEALTH_EN defined:
//  - Repetition-count test on the decimated samples: run counter of identical consecutive
//    samples. The counter starts at 1 on the first sample after reset or enable.
//  - alarm=1 on the cycle after the run reaches REP_LIMIT. It stays 1 until reset.
//  - While alarm=1: out_valid forced 0, no words are loaded, and the collector stops.
//  TRNG_HEALTH_EN undefined: no health logic, alarm tied 0.
// TESTING
//  1 Reset: assert reset mid-word with out_valid=1 -> out_valid=0, out_data=0, alarm=0
//    immediately. First word only after 8 fresh bits.
//  2 Debias/pack: WIDTH=8, DECIM=1, enable=1, out_ready=1. Drive pairs
//    10,01,10,10,01,01,10,01 (one bit/cycle) -> single out_valid pulse with out_data=8'hB2.
//  3 Discard: pairs 00,11 interleaved with 10 x8 -> out_data=8'hFF. Equal pairs contribute
//    no bits.
//  4 Backpressure: out_ready=0, feed 24 debiased bits -> first word held stable, second
//    pending. Raise out_ready one cycle -> 2 transfers on consecutive cycles; the 3rd word's
//    bits were dropped.
//  5 Enable drop: deassert enable between the two samples of a pair, re-enable with pair 01
//    -> emitted bit is 0. The stale first sample is not used.
//  6 Health (TRNG_HEALTH_EN, REP_LIMIT=32, DECIM=1): raw_in=1 constant -> alarm=1 the cycle
//    after the 32nd sample, out_valid stays 0. Without the macro: alarm=0 and no words.

Source files
------------

// File: rtl/trng_collector.sv
// Ring-oscillator entropy collector: resync, decimate, von Neumann debias, pack into words.
// Optional repetition-count health test is compiled in with `define TRNG_HEALTH_EN.
module trng_collector #(
  parameter int WIDTH     = 8,
  parameter int DECIM     = 4,
  parameter int REP_LIMIT = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             raw_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             alarm
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  if (WIDTH < 2 || DECIM < 1 || REP_LIMIT < 2) begin : g_param_check
    $error("trng_collector: WIDTH>=2, DECIM>=1, REP_LIMIT>=2 required");
  end

  typedef enum logic {EMPTY, HAVE_FIRST} state_t;

  logic             raw_p0, raw_p1;
  logic [CNT_W-1:0] dec_cnt;
  logic             smp_vld_p1;
  state_t           state;
  logic             first_bit;
  logic             emit_vld_p2, emit_bit_p2;
  logic [WIDTH-1:0] sreg;
  logic [BIT_W-1:0] bit_cnt;
  logic             word_full, load;
  logic             alarm_set;

  // Stage p0/p1: two-flop resynchroniser and decimation strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_p0 <= 1'b0;
      raw_p1 <= 1'b0;
    end else begin
      raw_p0 <= raw_in;
      raw_p1 <= raw_p0;
    end
  end

  assign smp_vld_p1 = enable && !alarm && (dec_cnt == CNT_W'(DECIM - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      dec_cnt <= '0;
    else if (!enable || alarm || smp_vld_p1)
      dec_cnt <= '0;
    else
      dec_cnt <= dec_cnt + CNT_W'(1);
  end

  // Stage p2: von Neumann pair decision, one bit emitted per unequal pair
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      first_bit   <= 1'b0;
      emit_vld_p2 <= 1'b0;
      emit_bit_p2 <= 1'b0;
    end else begin
      emit_vld_p2 <= 1'b0;
      if (!enable) begin
        state <= EMPTY;
      end else if (smp_vld_p1) begin
        case (state)
          EMPTY: begin
            first_bit <= raw_p1;
            state     <= HAVE_FIRST;
          end
          HAVE_FIRST: begin
            emit_vld_p2 <= (raw_p1 != first_bit);
            emit_bit_p2 <= first_bit;
            state       <= EMPTY;
          end
        endcase
      end
    end
  end

  // Stage p3: packing and output handshake
  assign word_full = (bit_cnt == BIT_W'(WIDTH));
  assign load      = word_full && (!out_valid || out_ready) && !alarm && !alarm_set;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        out_data <= sreg;
        bit_cnt  <= emit_vld_p2 ? BIT_W'(1) : BIT_W'(0);
        if (emit_vld_p2)
          sreg <= {sreg[WIDTH-2:0], emit_bit_p2};
      end else if (emit_vld_p2 && !word_full) begin
        // a bit arriving while a finished word still waits is dropped
        sreg    <= {sreg[WIDTH-2:0], emit_bit_p2};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      if (alarm || alarm_set)
        out_valid <= 1'b0;
      else if (load)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  logic [RUN_W-1:0] run_cnt, run_next;
  logic             last_smp;

  always_comb begin
    run_next = run_cnt;
    if (run_cnt == '0 || raw_p1 != last_smp)
      run_next = RUN_W'(1);
    else if (run_cnt < RUN_W'(REP_LIMIT))
      run_next = run_cnt + RUN_W'(1);
  end

  assign alarm_set = smp_vld_p1 && (run_next == RUN_W'(REP_LIMIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt  <= '0;
      last_smp <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      if (!enable) begin
        run_cnt <= '0;
      end else if (smp_vld_p1) begin
        run_cnt  <= run_next;
        last_smp <= raw_p1;
      end
      if (alarm_set)
        alarm <= 1'b1;
    end
  end
`else
  assign alarm_set = 1'b0;
  assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector (WIDTH=8, DECIM=1): vector table plus reset,
// backpressure, enable-drop and constant-input sequences.
module tb_trng_collector;

  localparam int WIDTH = 8;
`ifdef TRNG_HEALTH_EN
  localparam logic HEALTH = 1'b1;
`else
  localparam logic HEALTH = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, enable, raw_in, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, alarm;

  always #5 clock = ~clock;

  trng_collector #(.WIDTH(WIDTH), .DECIM(1), .REP_LIMIT(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .raw_in    (raw_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alarm     (alarm)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [WIDTH-1:0] words[$];
  int               xfer_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      words.push_back(out_data);
      xfer_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [31:0] bits;
    int          n;
    int          nw;
    logic [7:0]  w0;
    logic [7:0]  w1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // raw bits go out MSB first (bits[n-1] is the first sample); enable rises
  // exactly when the first bit reaches the end of the synchroniser
  task automatic run_stream(input logic [31:0] bits, input int n);
    for (int j = 0; j < n + 2; j++) begin
      raw_in = (j < n) ? bits[n-1-j] : 1'b0;
      enable = (j >= 2);
      tick();
    end
    enable = 1'b0;
    raw_in = 1'b0;
    repeat (6) tick();
  endtask

  function automatic logic [31:0] word_at(input int k);
    return (k < words.size()) ? 32'(words[k]) : 32'hDEAD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h9A59,     16, 1, 8'hB2, 8'h00};
    vecs[1] = '{32'h2E2E2E2E, 32, 1, 8'hFF, 8'h00};
    vecs[2] = '{32'h5555,     16, 1, 8'h00, 8'h00};
    vecs[3] = '{32'h9999,     16, 1, 8'hAA, 8'h00};
    vecs[4] = '{32'h355AA,    18, 1, 8'h0F, 8'h00};
    vecs[5] = '{32'hAA556666, 32, 2, 8'hF0, 8'h55};

    reset = 1'b1; enable = 1'b0; raw_in = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_alarm", 32'(alarm),     32'd0);
    reset = 1'b0;
    tick();

    // reset in the middle of a word while a word is held
    words.delete();
    run_stream(32'h9A59, 16);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_data",  32'(out_data),  32'hB2);
    run_stream(32'h55, 8);
    check("hold_data2", 32'(out_data),  32'hB2);
    check("hold_noxfer", 32'(words.size()), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_data",  32'(out_data),  32'd0);
    check("async_alarm", 32'(alarm),     32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    words.delete();
    run_stream(32'h99, 8);
    check("fresh_partial", 32'(words.size()), 32'd0);
    run_stream(32'hAA, 8);
    check("fresh_count", 32'(words.size()), 32'd1);
    check("fresh_word",  word_at(0),        32'hAF);

    // vector table
    for (int v = 0; v < 6; v++) begin
      words.delete();
      out_ready = 1'b1;
      run_stream(vecs[v].bits, vecs[v].n);
      check($sformatf("vec%0d_count", v), 32'(words.size()), 32'(vecs[v].nw));
      check($sformatf("vec%0d_w0", v), word_at(0), 32'(vecs[v].w0));
      if (vecs[v].nw > 1)
        check($sformatf("vec%0d_w1", v), word_at(1), 32'(vecs[v].w1));
      check($sformatf("vec%0d_valid_low", v), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_alarm", v), 32'(alarm), 32'd0);
    end

    // backpressure: word 1 held, word 2 pending, word 3 dropped
    words.delete();
    xfer_cyc.delete();
    out_ready = 1'b0;
    run_stream(32'h9A59, 16);
    run_stream(32'h9999, 16);
    run_stream(32'h55AA, 16);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_stable", 32'(out_data), 32'hB2);
      tick();
    end
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    check("bp_count", 32'(words.size()), 32'd2);
    check("bp_w0", word_at(0), 32'hB2);
    check("bp_w1", word_at(1), 32'hAA);
    check("bp_b2b", (xfer_cyc.size() == 2) ? 32'(xfer_cyc[1] - xfer_cyc[0]) : 32'hDEAD, 32'd1);
    check("bp_valid_end", 32'(out_valid), 32'd0);

    // enable dropped after the first sample of a pair: stale sample discarded
    words.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_stream(32'h1, 1);
      run_stream(32'h1, 2);
    end
    check("endrop_count", 32'(words.size()), 32'd1);
    check("endrop_word",  word_at(0),        32'h00);

    // constant input: no debiased bits; trips the health test when compiled in
    words.delete();
    run_stream(32'hFFFFFFFF, 32);
    check("const_words", 32'(words.size()), 32'd0);
    check("const_alarm", 32'(alarm), 32'(HEALTH));
    check("const_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
